// File: rtl/fir_sequencer.sv
// rtl/fir_sequencer.sv - coefficient loader, sample sequencer and watchdog for one fir
//
// Collects a coefficient set over a config handshake, shifts it into the fir's
// bit-serial coefficient chain, then issues one fir run per accepted sample and
// returns the result on an output stream.
//
// Ports:
//   clk, rstN                      clock, asynchronous active-low reset
//   cfg_valid/cfg_ready/cfg_data   coefficient word stream; cfg_sym taken with last word
//   in_valid/in_ready/in_data      input sample stream
//   out_valid/out_ready/out_data   filtered sample stream
//   coeffs_loaded, busy            status: full set resident in fir / state not IDLE
//   timeout_err                    sticky: fir_done missed its deadline
//   fir_start, fir_lock, fir_sym   fir control
//   fir_coeff_load, fir_coeff_bit  fir coefficient chain
//   fir_x, fir_done, fir_y         fir sample in, completion, result
module fir_sequencer #(
  parameter int DataWidth     = 12,
  parameter int NTaps         = 9,
  parameter int TimeoutCycles = 127
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [DataWidth-1:0] cfg_data,
  input  logic                 cfg_sym,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataWidth-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataWidth-1:0] out_data,
  output logic                 coeffs_loaded,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 fir_start,
  output logic                 fir_lock,
  output logic                 fir_sym,
  output logic                 fir_coeff_load,
  output logic                 fir_coeff_bit,
  output logic [DataWidth-1:0] fir_x,
  input  logic                 fir_done,
  input  logic [DataWidth-1:0] fir_y
);

  localparam int NCoeffs = (NTaps + 1) / 2;
  localparam int CntW    = (NCoeffs > 1) ? $clog2(NCoeffs) : 1;
  localparam int BitW    = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam int WdW     = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {IDLE, LOAD, GUARD, START, BUSY} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CntW-1:0]      cfg_cnt;
  logic [CntW-1:0]      load_word;
  logic [BitW-1:0]      load_bit;
  logic [DataWidth-1:0] coef_buf [NCoeffs];
  logic [WdW-1:0]       wdog;

  logic cfg_take;
  logic cfg_last;
  logic in_take;
  logic load_last;
  logic wdog_expired;

  assign cfg_take     = cfg_valid && cfg_ready;
  assign cfg_last     = cfg_take && (cfg_cnt == CntW'(NCoeffs - 1));
  assign in_take      = in_valid && in_ready;
  assign load_last    = (load_word == '0) && (load_bit == '0);
  // wdog counts BUSY cycles from 0, so this fires on the TimeoutCycles-th cycle after fir_start
  assign wdog_expired = (wdog == WdW'(TimeoutCycles - 1));
  // Each run rotates the fir chain a full turn, so no lock is ever needed
  assign fir_lock     = 1'b0;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_last) begin
          state_nxt = LOAD;
        end else if (in_take) begin
          state_nxt = START;
        end
      end
      LOAD:    if (load_last) state_nxt = GUARD;
      GUARD:   state_nxt = IDLE;
      START:   state_nxt = BUSY;
      BUSY:    if (fir_done || wdog_expired) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready      = 1'b0;
    in_ready       = 1'b0;
    fir_start      = 1'b0;
    fir_coeff_load = 1'b0;
    fir_coeff_bit  = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        // A pending or partially collected config set takes priority over samples
        in_ready  = coeffs_loaded && !out_valid && (cfg_cnt == '0) && !cfg_valid;
      end
      LOAD: begin
        fir_coeff_load = 1'b1;
        fir_coeff_bit  = coef_buf[load_word][load_bit];
      end
      START:   fir_start = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cfg_cnt       <= '0;
      load_word     <= '0;
      load_bit      <= '0;
      wdog          <= '0;
      fir_sym       <= 1'b1;
      fir_x         <= '0;
      coeffs_loaded <= 1'b0;
      timeout_err   <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      for (int i = 0; i < NCoeffs; i++) begin
        coef_buf[i] <= '0;
      end
    end else begin
      if (cfg_take) begin
        coef_buf[cfg_cnt] <= cfg_data;
        if (cfg_cnt == '0) begin
          coeffs_loaded <= 1'b0;
          timeout_err   <= 1'b0;
        end
        if (cfg_last) begin
          fir_sym   <= cfg_sym;
          cfg_cnt   <= '0;
          // Shift out the highest word first so word 0 ends nearest the chain tail
          load_word <= CntW'(NCoeffs - 1);
          load_bit  <= BitW'(DataWidth - 1);
        end else begin
          cfg_cnt <= cfg_cnt + 1'b1;
        end
      end

      if (in_take) begin
        fir_x <= in_data;
      end

      if (state == LOAD) begin
        if (load_bit == '0) begin
          load_bit  <= BitW'(DataWidth - 1);
          load_word <= load_word - 1'b1;
        end else begin
          load_bit <= load_bit - 1'b1;
        end
      end

      if (state == GUARD) begin
        coeffs_loaded <= 1'b1;
      end

      if (state == START) begin
        wdog <= '0;
      end

      if (state == BUSY) begin
        wdog <= wdog + 1'b1;
        if (fir_done) begin
          out_data  <= fir_y;
          out_valid <= 1'b1;
        end else if (wdog_expired) begin
          timeout_err <= 1'b1;
        end
      end

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// tb/tb_fir_sequencer.sv - self-checking bench for fir_sequencer with a behavioural fir
module tb_fir_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [11:0] cfg_data = '0;
  logic        cfg_sym = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_data;
  logic        coeffs_loaded;
  logic        busy;
  logic        timeout_err;
  logic        fir_start;
  logic        fir_lock;
  logic        fir_sym;
  logic        fir_coeff_load;
  logic        fir_coeff_bit;
  logic [11:0] fir_x;
  logic        fir_done;
  logic [11:0] fir_y;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fir_sequencer dut (
    .clk(clk), .rstN(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_sym(cfg_sym),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coeffs_loaded(coeffs_loaded), .busy(busy), .timeout_err(timeout_err),
    .fir_start(fir_start), .fir_lock(fir_lock), .fir_sym(fir_sym),
    .fir_coeff_load(fir_coeff_load), .fir_coeff_bit(fir_coeff_bit),
    .fir_x(fir_x), .fir_done(fir_done), .fir_y(fir_y)
  );

  // Symmetric 9-tap FIR: tap k uses coefficient word min(k, 8-k); upper taps negated
  // and centre zeroed for the anti-symmetric case. Q11 coefficients.
  function automatic logic [11:0] compute_y(input logic [59:0] cw, input logic sym,
                                            input logic [107:0] hv);
    longint acc;
    longint s;
    longint c;
    int     idx;
    acc = 0;
    for (int k = 0; k < 9; k++) begin
      idx = (k < 5) ? k : 8 - k;
      s = longint'($signed(hv[k*12 +: 12]));
      c = longint'($signed(cw[idx*12 +: 12]));
      if (!sym && k > 4) c = -c;
      if (!sym && k == 4) c = 0;
      acc += s * c;
    end
    acc = acc >>> 11;
    return acc[11:0];
  endfunction

  // Behavioural fir: serial chain, sample history, done 61 cycles after start
  logic [59:0]  chain;
  logic [107:0] hist;
  logic [11:0]  y_reg;
  int           dcnt;
  logic         suppress_done = 1'b0;
  logic         force_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      hist  <= '0;
      y_reg <= '0;
      dcnt  <= 0;
    end else begin
      if (fir_coeff_load) chain <= {chain[58:0], fir_coeff_bit};
      if (fir_start) begin
        hist  <= {hist[95:0], fir_x};
        y_reg <= compute_y(chain, fir_sym, {hist[95:0], fir_x});
        dcnt  <= 61;
      end else if (dcnt > 0) begin
        dcnt <= dcnt - 1;
      end
    end
  end

  assign fir_done = ((dcnt == 1) && !suppress_done) || force_done;
  assign fir_y    = y_reg;

  // Event monitor
  int cyc = 0;
  int start_cnt = 0;
  int load_cnt = 0;
  int last_start_cyc = 0;
  int last_load_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fir_start) begin
      start_cnt      <= start_cnt + 1;
      last_start_cyc <= cyc;
    end
    if (fir_coeff_load) begin
      load_cnt      <= load_cnt + 1;
      last_load_cyc <= cyc;
    end
  end

  // Reference state: configured words, symmetry, and expected fir history
  logic [59:0]  cfg_pack = '0;
  logic         cfg_symv = 1'b1;
  logic [107:0] hv_exp = '0;

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hv_exp = '0;
    @(negedge clk);
  endtask

  task automatic push_cfg(input logic [59:0] words, input logic sym);
    int n;
    for (int k = 0; k < 5; k++) begin
      cfg_valid = 1'b1;
      cfg_data  = words[k*12 +: 12];
      cfg_sym   = sym;
      n = 0;
      while (!cfg_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (cfg_ready !== 1'b1) $display("FAIL cfg_wait word %0d: cfg_ready=%b want 1", k, cfg_ready);
      else passed++;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [59:0] words, input logic sym);
    int n;
    int l0;
    l0 = load_cnt;
    push_cfg(words, sym);
    checks++;
    if ({coeffs_loaded, timeout_err, fir_coeff_load} !== 3'b001)
      $display("FAIL load_begin: loaded/terr/load=%b want 001", {coeffs_loaded, timeout_err, fir_coeff_load});
    else passed++;
    n = 0;
    while (!coeffs_loaded && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (coeffs_loaded !== 1'b1) $display("FAIL load_done: coeffs_loaded=%b want 1", coeffs_loaded);
    else passed++;
    checks++;
    if (load_cnt - l0 !== 60) $display("FAIL load_len: got %0d cycles want 60", load_cnt - l0);
    else passed++;
    checks++;
    if (chain !== words) $display("FAIL load_chain: got %h want %h", chain, words);
    else passed++;
    checks++;
    if (cyc - last_load_cyc !== 2) $display("FAIL load_guard: loaded %0d cycles after last load bit, want 2", cyc - last_load_cyc);
    else passed++;
    checks++;
    if (fir_sym !== sym) $display("FAIL load_sym: fir_sym=%b want %b", fir_sym, sym);
    else passed++;
    cfg_pack = words;
    cfg_symv = sym;
  endtask

  task automatic accept_sample(input logic [11:0] x);
    int n;
    in_valid = 1'b1;
    in_data  = x;
    n = 0;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) $display("FAIL accept_wait: in_ready=%b want 1", in_ready);
    else passed++;
    @(negedge clk);
    in_valid = 1'b0;
    hv_exp = {hv_exp[95:0], x};
  endtask

  task automatic send_and_check(input logic [11:0] x, input logic [11:0] exp_y);
    int n;
    int s0;
    s0 = start_cnt;
    accept_sample(x);
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) $display("FAIL out_wait: out_valid=%b want 1", out_valid);
    else passed++;
    checks++;
    if (out_data !== exp_y) $display("FAIL out_data x=%0d: got %0d want %0d", $signed(x), $signed(out_data), $signed(exp_y));
    else passed++;
    checks++;
    if (cyc - last_start_cyc !== 62) $display("FAIL out_latency: got %0d want 62", cyc - last_start_cyc);
    else passed++;
    checks++;
    if (start_cnt - s0 !== 1) $display("FAIL start_count: got %0d want 1", start_cnt - s0);
    else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL drain: out_valid/in_ready=%b want 01", {out_valid, in_ready});
    else passed++;
  endtask

  task automatic test_reset();
    int rdy_seen;
    int s0;
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 12'd77;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, fir_start, out_valid, fir_coeff_load, fir_coeff_bit, busy, coeffs_loaded,
         timeout_err, fir_lock, fir_sym} !== 10'b0000000001)
      $display("FAIL reset_flags: got %b want 0000000001", {in_ready, fir_start, out_valid,
               fir_coeff_load, fir_coeff_bit, busy, coeffs_loaded, timeout_err, fir_lock, fir_sym});
    else passed++;
    checks++;
    if ({out_data, fir_x} !== 24'h0) $display("FAIL reset_data: out_data=%h fir_x=%h want 0", out_data, fir_x);
    else passed++;
    rst_n = 1'b1;
    s0 = start_cnt;
    rdy_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (in_ready) rdy_seen++;
    end
    checks++;
    if (rdy_seen !== 0) $display("FAIL reset_no_ready: in_ready high %0d cycles want 0", rdy_seen);
    else passed++;
    checks++;
    if (start_cnt - s0 !== 0) $display("FAIL reset_no_start: %0d starts want 0", start_cnt - s0);
    else passed++;
    in_valid = 1'b0;
  endtask

  task automatic test_load();
    load_cfg({12'h005, 12'h004, 12'h003, 12'h002, 12'h001}, 1'b1);
    checks++;
    if (chain[59:48] !== 12'h005) $display("FAIL load_first_word: got %h want 005", chain[59:48]);
    else passed++;
    checks++;
    if (chain[11:0] !== 12'h001) $display("FAIL load_last_word: got %h want 001", chain[11:0]);
    else passed++;
  endtask

  task automatic test_impulse();
    logic [11:0] xs  [6];
    logic [11:0] exp [6];
    xs  = '{12'd1000, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
    exp = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd500, 12'd0};
    load_cfg({12'h400, 48'h0}, 1'b1);
    for (int i = 0; i < 6; i++) send_and_check(xs[i], exp[i]);
  endtask

  task automatic test_backpressure();
    logic [11:0] held;
    logic [11:0] exp_y;
    int          unstable;
    int          rdy_seen;
    int          s0;
    int          n;
    exp_y = compute_y(cfg_pack, cfg_symv, {hv_exp[95:0], 12'd600});
    accept_sample(12'd600);
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_data !== exp_y) $display("FAIL bp_data: got %0d want %0d", $signed(out_data), $signed(exp_y));
    else passed++;
    held = out_data;
    in_valid = 1'b1;
    in_data = 12'd5;
    s0 = start_cnt;
    unstable = 0;
    rdy_seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (!out_valid || out_data !== held) unstable++;
      if (in_ready) rdy_seen++;
    end
    in_valid = 1'b0;
    checks++;
    if (unstable !== 0) $display("FAIL bp_stable: %0d unstable cycles want 0", unstable);
    else passed++;
    checks++;
    if (rdy_seen !== 0) $display("FAIL bp_in_ready: high %0d cycles want 0", rdy_seen);
    else passed++;
    checks++;
    if (start_cnt - s0 !== 0) $display("FAIL bp_start: %0d starts want 0", start_cnt - s0);
    else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_random();
    logic [59:0] words;
    logic        sym;
    logic [11:0] x;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 5; k++) words[k*12 +: 12] = 12'($urandom_range(0, 512) - 256);
      sym = 1'($urandom_range(0, 1));
      load_cfg(words, sym);
      for (int i = 0; i < 8; i++) begin
        x = 12'($urandom_range(0, 1000) - 500);
        send_and_check(x, compute_y(cfg_pack, cfg_symv, {hv_exp[95:0], x}));
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    int ov_seen;
    suppress_done = 1'b1;
    accept_sample(12'd321);
    ov_seen = 0;
    while (cyc - last_start_cyc < 100) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    checks++;
    if ({busy, timeout_err} !== 2'b10) $display("FAIL to_early: busy/terr=%b want 10", {busy, timeout_err});
    else passed++;
    n = 0;
    while (!timeout_err && n < 60) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
      n++;
    end
    checks++;
    if (timeout_err !== 1'b1) $display("FAIL to_flag: timeout_err=%b want 1", timeout_err);
    else passed++;
    checks++;
    if (cyc - last_start_cyc < 127 || cyc - last_start_cyc > 129)
      $display("FAIL to_time: flagged %0d cycles after start want 127..129", cyc - last_start_cyc);
    else passed++;
    checks++;
    if ({busy, out_valid} !== 2'b00 || ov_seen !== 0)
      $display("FAIL to_idle: busy/out_valid=%b out_valid cycles=%0d want 00/0", {busy, out_valid}, ov_seen);
    else passed++;
    suppress_done = 1'b0;
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, timeout_err} !== 3'b001)
      $display("FAIL stray_done: out_valid/busy/terr=%b want 001", {out_valid, busy, timeout_err});
    else passed++;
    load_cfg({12'h010, 12'h020, 12'h030, 12'h040, 12'h050}, 1'b0);
    checks++;
    if (timeout_err !== 1'b0) $display("FAIL to_clear: timeout_err=%b want 0", timeout_err);
    else passed++;
  endtask

  task automatic check_refused(input string tag);
    int rdy_seen;
    int s0;
    in_valid = 1'b1;
    in_data = 12'd9;
    s0 = start_cnt;
    rdy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (in_ready) rdy_seen++;
    end
    in_valid = 1'b0;
    checks++;
    if (rdy_seen !== 0 || start_cnt - s0 !== 0)
      $display("FAIL %s_refuse: in_ready cycles=%0d starts=%0d want 0/0", tag, rdy_seen, start_cnt - s0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    push_cfg({12'h111, 12'h222, 12'h333, 12'h444, 12'h555}, 1'b1);
    repeat (20) @(negedge clk);
    checks++;
    if (fir_coeff_load !== 1'b1) $display("FAIL mid_load_active: fir_coeff_load=%b want 1", fir_coeff_load);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({fir_coeff_load, fir_coeff_bit, busy, coeffs_loaded, fir_start, out_valid, in_ready} !== 7'b0)
      $display("FAIL mid_load_reset: got %b want 0000000", {fir_coeff_load, fir_coeff_bit, busy,
               coeffs_loaded, fir_start, out_valid, in_ready});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    hv_exp = '0;
    check_refused("mid_load");

    load_cfg({12'h100, 12'h0F0, 12'h0E0, 12'h0D0, 12'h0C0}, 1'b1);
    accept_sample(12'd250);
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b1) $display("FAIL mid_busy_active: busy=%b want 1", busy);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, coeffs_loaded, fir_start, out_valid, timeout_err, fir_x} !== 17'b0)
      $display("FAIL mid_busy_reset: got %b want 0", {busy, coeffs_loaded, fir_start, out_valid, timeout_err, fir_x});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    hv_exp = '0;
    check_refused("mid_busy");
    load_cfg({12'h100, 12'h0F0, 12'h0E0, 12'h0D0, 12'h0C0}, 1'b1);
    send_and_check(12'd250, compute_y(cfg_pack, cfg_symv, {hv_exp[95:0], 12'd250}));
  endtask

  initial begin
    test_reset();
    test_load();
    test_impulse();
    test_backpressure();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/fir_sequencer.md
Name: fir_sequencer

Overview:
- Controller that owns one `fir` instance.
- Collects a coefficient set over a word-wide config handshake, serializes it into the FIR's bit-serial coefficient chain, and accepts input samples over a valid/ready stream.
- Issues one `start` per sample, waits for `done`, and presents `y` on a valid/ready output stream.
- Provides a done-timeout watchdog and status flags for the top level.

Parameters:
- DataWidth, 12, sample/coefficient width; must match the attached fir.
- NTaps, 9, FIR tap count (odd); NCoeffs = (NTaps+1)/2 is derived.
- TimeoutCycles, 127, maximum cycles from fir_start to fir_done before a timeout is flagged.

Ports:
- clk  in  1  clock.
- rstN  in  1  reset; asynchronous, active-low.
- cfg_valid  in  1  coefficient word valid.
- cfg_ready  out  1  coefficient word accepted when both valid and ready are high.
- cfg_data  in  DataWidth  coefficient word, SFix<1,DataWidth-1>.
- cfg_sym  in  1  symmetric(1)/anti-symmetric(0); sampled with the last word of a set.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input sample accepted when both valid and ready are high.
- in_data  in  DataWidth  signed input sample.
- out_valid  out  1  filtered sample valid.
- out_ready  in  1  downstream accepts the filtered sample.
- out_data  out  DataWidth  signed filtered sample.
- coeffs_loaded  out  1  a complete coefficient set resides in the fir.
- busy  out  1  state is not IDLE.
- timeout_err  out  1  sticky watchdog flag.
- fir_start  out  1  to fir.start.
- fir_lock  out  1  to fir.lock; constant 0.
- fir_sym  out  1  to fir.symCoeffs; registered cfg_sym.
- fir_coeff_load  out  1  to fir.coeff_load_in.
- fir_coeff_bit  out  1  to fir.coeff_in.
- fir_x  out  DataWidth  to fir.x; registered sample.
- fir_done  in  1  from fir.done.
- fir_y  in  DataWidth  from fir.y.

Behaviour:
- Reset (rstN low, asynchronous): state=IDLE; all outputs 0; cfg word counter 0; coefficient buffer 0; fir_sym=1. The fir shares rstN.
- States: IDLE, LOAD, GUARD, START, BUSY.
- Config collection:
  - cfg_ready = (state==IDLE).
  - Each accepted word is written to buf[cfg_cnt] and cfg_cnt increments. Word k targets fir coeffs[k]; k = NCoeffs-1 multiplies the centre tap.
  - The first accepted word of a set clears coeffs_loaded and timeout_err.
  - The word with cfg_cnt==NCoeffs-1 also latches cfg_sym into fir_sym, resets cfg_cnt to 0, and moves IDLE->LOAD.
- LOAD:
  - fir_coeff_load=1 for exactly NCoeffs*DataWidth consecutive cycles (60 for defaults).
  - Bit order is buf[NCoeffs-1] MSB first, down to buf[0] LSB last, so each word lands in its own fir register.
  - Then LOAD->GUARD.
- GUARD: one cycle with fir_coeff_load=0, letting the fir return to IDLE. Sets coeffs_loaded=1, then GUARD->IDLE.
- Sample acceptance:
  - in_ready = IDLE && coeffs_loaded && !out_valid && cfg_cnt==0 && !cfg_valid. Config has priority; a partially collected set blocks samples.
  - On acceptance, in_data is registered into fir_x and the state moves IDLE->START.
- START: fir_start=1 for exactly one cycle, with fir_x stable. Watchdog counter cleared. Then START->BUSY.
- BUSY:
  - fir_x held stable; watchdog increments each cycle.
  - fir_done=1: out_data<=fir_y, out_valid<=1 (visible the next cycle), then BUSY->IDLE.
  - Watchdog reaches TimeoutCycles without done: timeout_err<=1, out_valid stays 0, then BUSY->IDLE. A later stray done outside BUSY is ignored.
- Nominal latency (defaults): fir_done occurs 61 cycles after the fir_start cycle.
- Output stream:
  - out_valid holds with out_data stable until out_valid&&out_ready, then clears.
  - The next sample cannot be accepted while out_valid=1; acceptance may occur in the cycle after the drain.
- Simultaneous cfg_valid and in_valid in IDLE: cfg is taken, the sample waits.
- fir_done while in IDLE, LOAD or GUARD: ignored.
- fir_lock is tied 0: each run applies NCoeffs rotations, which restores coefficient order.
- Reset mid-LOAD or mid-BUSY: everything returns to reset values, coeffs_loaded=0, and a full reload is required.

Test Plan:
- Reset with in_valid=1 and no coefficients loaded -> in_ready=0; no fir_start for 100 cycles; all outputs 0.
- Config words 0x001,0x002,0x003,0x004,0x005 with sym=1 -> exactly 60 fir_coeff_load cycles. The first 12 bits of fir_coeff_bit are 0x005 MSB-first; the last 12 are 0x001 MSB-first. coeffs_loaded rises after the guard cycle.
- Words c4=0x400, others 0, sym=1; samples 1000,0,0,0,0,0 -> outputs 0,0,0,0,500,0 in order. Exactly one fir_start per sample; out_valid rises 62 cycles after each fir_start.
- out_ready held 0 for 200 cycles after the first output -> out_valid/out_data stable, in_ready=0 throughout, no extra fir_start.
- fir_done forced low during BUSY -> timeout_err=1 after 127 cycles, out_valid stays 0, state IDLE. A new config set clears timeout_err.
- rstN asserted asynchronously mid-LOAD and again mid-BUSY -> all outputs 0 immediately, coeffs_loaded=0. Samples are refused until a reload completes.
